// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle MIPS control unit and its datapath.
// master : control unit side (takes opcode/mem_ready, drives every select and enable)
// slave  : datapath side
//   opcode_i      IR[31:26]
//   mem_ready_i   memory completes the current access this cycle
//   mem_req_o .. illegal_o  datapath mux selects, write enables and status pulses
//   state_o       current FSM state, for debug
interface mc_ctrl_if #(
    parameter int unsigned ST_W = 4
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;

    logic [OP_W-1:0]  opcode_i;
    logic             mem_ready_i;
    logic             mem_req_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic [SEL_W-1:0] PCSource_o;
    logic             ALUSrcA_o;
    logic [SEL_W-1:0] ALUSrcB_o;
    logic [SEL_W-1:0] ALUOp_o;
    logic [SEL_W-1:0] EXTOp_o;
    logic [SEL_W-1:0] RegDst_o;
    logic [SEL_W-1:0] MemtoReg_o;
    logic             RegWrite_o;
    logic             instr_done_o;
    logic             illegal_o;
    logic [ST_W-1:0]  state_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o,
               PCWriteCond_o, PCSource_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, EXTOp_o,
               RegDst_o, MemtoReg_o, RegWrite_o, instr_done_o, illegal_o, state_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o,
               PCWriteCond_o, PCSource_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, EXTOp_o,
               RegDst_o, MemtoReg_o, RegWrite_o, instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing ALU, unified memory port,
// IR, PC and register file over 3-5 cycles per instruction, with wait states
// on FETCH/MEMRD/MEMWR until the memory reports ready.
//   clk_i    system clock, rising edge
//   rst_n_i  asynchronous active-low reset (returns to IDLE, all outputs 0)
//   bus      control bus (master side), see mc_ctrl_if
module mc_ctrl #(
    parameter int unsigned ST_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    mc_ctrl_if.master  bus
);
    localparam int unsigned ENC_W = 4;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    typedef enum logic [ENC_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_ORIEX  = 4'd9,
        S_ORIWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             mem_req;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [SEL_W-1:0] pc_source;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] ext_op;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem_to_reg;
    logic             reg_write;
    logic             instr_done;
    logic             illegal;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs; only FETCH/MEMRD/MEMWR look at mem_ready_i
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        ext_op        = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle; IR and PC only load once memory is ready
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready_i;
                pc_write  = bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut <= PC + (sext(imm) << 2): branch target ready for BRANCH
                alu_src_b = 2'b11;
                ext_op    = 2'b01;
                case (bus.opcode_i)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_ORI:        state_d = S_ORIEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 2'b01;
                state_d   = (bus.opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready_i) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_ORIWB;
            end
            S_ORIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                // JAL links PC (already PC+4) into $31
                if (bus.opcode_i == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req_o     = mem_req;
    assign bus.IorD_o        = iord;
    assign bus.MemRead_o     = mem_read;
    assign bus.MemWrite_o    = mem_write;
    assign bus.IRWrite_o     = ir_write;
    assign bus.PCWrite_o     = pc_write;
    assign bus.PCWriteCond_o = pc_write_cond;
    assign bus.PCSource_o    = pc_source;
    assign bus.ALUSrcA_o     = alu_src_a;
    assign bus.ALUSrcB_o     = alu_src_b;
    assign bus.ALUOp_o       = alu_op;
    assign bus.EXTOp_o       = ext_op;
    assign bus.RegDst_o      = reg_dst;
    assign bus.MemtoReg_o    = mem_to_reg;
    assign bus.RegWrite_o    = reg_write;
    assign bus.instr_done_o  = instr_done;
    assign bus.illegal_o     = illegal;
    assign bus.state_o       = ST_W'(state_q);

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS datapath: a Moore FSM with memory-handshake qualification that sequences the shared ALU, the single unified memory port, IR, PC and register file over 3–5 cycles per instruction.
- Supports R-type, ORI, LW, SW, BEQ, J and JAL. Replaces the single-cycle decoder in the multi-cycle CPU top level.
- Consumes opcode from the instruction register. Drives all datapath mux selects and write enables.

Parameters:
- ST_W, 4, width of state register and state_o.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- opcode_i  input  6  IR[31:26]; stable from DECODE until the next FETCH completes.
- mem_ready_i  input  1  memory completes the current access this cycle.
- mem_req_o  output  1  memory access request.
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead_o  output  1  memory read.
- MemWrite_o  output  1  memory write.
- IRWrite_o  output  1  load IR.
- PCWrite_o  output  1  unconditional PC load.
- PCWriteCond_o  output  1  PC load if ALU zero.
- PCSource_o  output  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ALUSrcA_o  output  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB_o  output  2  ALU B input: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- ALUOp_o  output  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- EXTOp_o  output  2  00 = zero extend, 01 = sign extend.
- RegDst_o  output  2  00 = rd, 01 = rt, 10 = $31.
- MemtoReg_o  output  2  00 = ALUOut, 01 = MDR, 10 = PC (link).
- RegWrite_o  output  1  register file write enable.
- instr_done_o  output  1  one-cycle pulse when an instruction retires.
- illegal_o  output  1  one-cycle pulse on an undefined opcode.
- state_o  output  ST_W  current state, for debug.

Behaviour:
- Reset (asynchronous, rst_n_i low): state = IDLE.
  - In IDLE every output is 0, state_o = 0.
  - IDLE → FETCH unconditionally on the first clock edge after reset is released.
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, ORIEX=9, ORIWB=10, BRANCH=11, JUMP=12. Encodings 13–15 → IDLE on the next edge.
- Outputs are state-decoded. Any signal not listed for a state is 0.
- FETCH:
  - mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready_i (combinational qualification).
  - Stay in FETCH while mem_ready_i=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, EXTOp=01 (precomputes branch target). Next state by opcode:
  - 000000 → EXEC
  - 001101 → ORIEX
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 / 000011 → JUMP
  - any other opcode → FETCH, with illegal_o=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, EXTOp=01. Next: LW → MEMRD, SW → MEMWR.
- MEMRD: mem_req=1, MemRead=1, IorD=1. Wait for mem_ready_i, then → MEMWB.
- MEMWB: RegWrite=1, RegDst=01, MemtoReg=01, instr_done=1 → FETCH.
- MEMWR: mem_req=1, MemWrite=1, IorD=1. Wait for mem_ready_i. In the ready cycle instr_done=1 → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- RWB: RegWrite=1, RegDst=00, MemtoReg=00, instr_done=1 → FETCH.
- ORIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, EXTOp=00 → ORIWB.
- ORIWB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 → FETCH. If opcode_i=000011 (JAL), additionally RegWrite=1, RegDst=10, MemtoReg=10.
- Cycle counts with zero-wait memory:
  - LW 5
  - SW 4
  - R-type / ORI 4
  - BEQ / J / JAL 3
- Each wait state adds exactly one cycle. During waits, mem_req and all address/command selects are held stable.
- Ordering guarantees:
  - mem_ready_i is ignored in every state other than FETCH, MEMRD and MEMWR.
  - MemWrite is never asserted outside MEMWR.
  - RegWrite is asserted at most once per instruction.
- Reset asserted mid-instruction (including mid-wait): immediate return to IDLE, all outputs 0 in the same cycle. No partial write occurs after reset is asserted.

Test Plan:
- Reset release with mem_ready_i=1: state_o sequence 0 → 1 → 2. In the FETCH cycle IRWrite=PCWrite=1; all outputs were 0 during reset.
- LW (opcode 100011), ready held 1: state sequence 1, 2, 3, 4, 5. MEMWB has RegWrite=1, RegDst=01, MemtoReg=01; instr_done pulses once.
- SW with mem_ready_i low for 3 cycles in MEMWR: MemWrite=1, IorD=1 held for 4 cycles; then → FETCH; RegWrite never 1.
- R-type, then ORI, then BEQ back-to-back:
  - 4 + 4 + 3 cycles.
  - ALUOp in the execute states is 10, 11, 01 respectively.
  - PCWriteCond=1 only in BEQ's third cycle.
- JAL (000011): in JUMP, PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. J (000010): the same state, but RegWrite=0.
- Opcode 111111: illegal_o=1 in DECODE, next state FETCH, no RegWrite, MemWrite or PCWrite. Separately, rst_n_i dropped during a MEMRD wait: outputs go to 0 immediately and the FSM restarts from IDLE.
